// File: rtl/data_sram_responder.sv
// Data-side SRAM-like slave: word-addressed backing RAM plus an in-order queue of
// outstanding transactions, each answered a fixed LATENCY after acceptance.
module data_sram_responder #(
  parameter int MEM_AW      = 12,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        addr_block
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] r_mem [0:(1 << MEM_AW) - 1];
  logic [31:0] r_rd_data;
  logic        r_fill_pend;
  logic [PW-1:0] r_fill_idx;

  logic [OUTSTANDING-1:0] r_vld;
  logic [OUTSTANDING-1:0] r_is_wr;
  logic [3:0]  r_cnt  [OUTSTANDING];
  logic [31:0] r_data [OUTSTANDING];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_has_room;
  logic              w_head_rdy;
  logic [31:0]       w_head_data;
  logic [MEM_AW-1:0] w_idx;
  logic              w_unused;

  // size is informational and the aliased upper address bits are dropped.
  assign w_unused = ^{size, addr[31:MEM_AW+2], addr[1:0]};
  assign w_idx    = addr[MEM_AW+1:2];

  assign w_head_rdy = r_vld[r_head] & (r_cnt[r_head] == '0);
  assign data_ok    = w_head_rdy & ~reset;
  assign w_pop      = data_ok;
  assign w_has_room = (r_count < CW'(OUTSTANDING)) | w_pop;
  assign addr_ok    = req & ~reset & ~addr_block & w_has_room;
  assign w_push     = addr_ok;

  // The RAM read lands in r_rd_data one edge after acceptance; until it is copied
  // into its queue slot, the head mux forwards it directly (needed for LATENCY = 1).
  assign w_head_data = (r_fill_pend && r_fill_idx == r_head) ? r_rd_data : r_data[r_head];
  assign rdata       = (data_ok && !r_is_wr[r_head]) ? w_head_data : '0;

  always_ff @(posedge clk) begin
    if (w_push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    r_rd_data <= r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_fill_pend <= 1'b0;
      r_fill_idx  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      r_fill_pend <= w_push & ~wr;
      r_fill_idx  <= r_tail;
    end
  end

  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_entry
    // A push into a slot being popped in the same cycle (full queue) takes priority.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld[gi]   <= 1'b0;
        r_is_wr[gi] <= 1'b0;
        r_cnt[gi]   <= '0;
      end else if (w_push && r_tail == PW'(gi)) begin
        r_vld[gi]   <= 1'b1;
        r_is_wr[gi] <= wr;
        r_cnt[gi]   <= CNT_INIT;
      end else if (w_pop && r_head == PW'(gi)) begin
        r_vld[gi] <= 1'b0;
      end else if (r_vld[gi] && r_cnt[gi] != '0) begin
        r_cnt[gi] <= r_cnt[gi] - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (r_fill_pend && r_fill_idx == PW'(gi)) r_data[gi] <= r_rd_data;
    end
  end

endmodule
